cnn_conv_engine: RTL and testbench
==================================

Name: cnn_conv_engine

Overview:
- Single-channel 2-D convolution accelerator: slides a Y_M×Y_N signed 8-bit weight window over an X_M×X_N unsigned 8-bit data matrix in external memory.
- Adds a signed 32-bit bias to each dot product and applies ReLU plus saturation.
- Writes one activation byte per window back to memory.
- Sits between the software register block (addresses, sizes, go/done) and the memory fabric: three read ports (data, weights, bias) and one write port.

Parameters:
- ADDR_WIDTH, 19, memory byte-address width.
- X_ROWS_NUM / X_COLS_NUM, 28 / 28, maximum data matrix size.
- X_LOG2_ROWS_NUM / X_LOG2_COLS_NUM, clog2 of the above.
- Y_ROWS_NUM / Y_COLS_NUM, 5 / 5, maximum weight matrix size.
- Y_LOG2_ROWS_NUM / Y_LOG2_COLS_NUM, clog2 of the above.
- JUMP_COL / JUMP_ROW, 1 / 1, window stride in columns / rows.
- DP_DEPTH, 5, register stages from final row capture to result.
- ACT_SHIFT, 0, right shift applied before saturation.
- MAX_BYTES_TO_WR, 5, write-data width in bytes.

Ports:
- clk in 1 — clock.
- rst_n in 1 — asynchronous active-low reset.
- sw_cnn_go in 1 — start.
- sw_cnn_done out 1 — one-cycle pulse at end of run.
- cnn_sw_busy_ind out 1 — high while running.
- sw_cnn_addr_x / _y / _z / _bias in ADDR_WIDTH — base addresses of data, weights, output and bias.
- sw_cnn_x_m / sw_cnn_x_n in X_LOG2_ROWS_NUM+1 / X_LOG2_COLS_NUM+1 — data rows / cols.
- sw_cnn_y_m / sw_cnn_y_n in Y_LOG2_ROWS_NUM+1 / Y_LOG2_COLS_NUM+1 — weight rows / cols.
- For each read port P ∈ {pic, wgt, bias}:
  - P_mem_req out 1.
  - P_mem_start_addr out ADDR_WIDTH.
  - P_mem_size_bytes out 6.
  - P_mem_valid in 1.
  - P_mem_data in 256 — byte k at [8k+7:8k] is address start+k.
  - P_mem_last_valid in 5 — index of last valid byte.
  - P_last in 1 — ignored.
- wr_mem_req out 1.
- wr_mem_start_addr out ADDR_WIDTH.
- wr_mem_size_bytes out 3.
- wr_mem_data out 8*MAX_BYTES_TO_WR.
- wr_mem_ack in 1.
- data2write_out out 32 signed — debug: dot product plus bias.
- activation_out_smpl out 8 — debug: activation.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; accumulator and weight/bias registers cleared. Reset mid-run aborts immediately, with no done pulse.
- FSM: IDLE → RD_PIC0 → RD_WGT → RD_BIAS → RD_ROWS → CALC → WRITE → (RD_ROWS | DONE) → IDLE.
- Start: sw_cnn_go sampled high in IDLE starts a run. sw_* inputs are latched at start.
- busy is high from the cycle after start until the cycle of the done pulse.
- Read handshake:
  - Assert req together with start_addr and size; hold all three stable until the first cycle where req && valid.
  - Capture data in that cycle; drop req the next cycle.
  - Consecutive requests on one port are separated by at least one cycle with req low.
  - valid seen while that port's req is low is ignored, including valid held high for several cycles.
- RD_PIC0: row 0 of window 0, address addr_x, size y_n.
- RD_WGT: address addr_y, size y_m*y_n; weight (r,c) is byte r*y_n+c.
- RD_BIAS: address addr_bias, size 4; bias is bytes 0..3, little-endian, signed.
- Window geometry: window (i,j) has i in 0..(x_m-y_m)/JUMP_ROW and j in 0..(x_n-y_n)/JUMP_COL, scanned row-major (j fastest).
- RD_ROWS: for r = 0..y_m-1, read size y_n at addr_x + (i*JUMP_ROW + r)*x_n + j*JUMP_COL. Row 0 of window (0,0) was already read in RD_PIC0, so RD_ROWS starts at r = 1 for that window.
- Accumulate: on each row capture, acc += Σc data[c]*w[r][c], with data zero-extended, weights sign-extended, 32-bit signed accumulation.
- Result: DP_DEPTH cycles after the final row capture, data2write_out ← acc + bias and activation_out_smpl ← act(acc + bias). Both hold until the next window's result; acc then clears.
- Activation: if s < 0 then 0; else t = s >>> ACT_SHIFT, output min(t, 255).
- WRITE:
  - wr_mem_req high with start_addr = addr_z + window index, size 1, data byte 0 = activation.
  - Hold until wr_mem_ack is sampled high; drop the next cycle. Ack while not requesting is ignored.
- DONE: after the last window's write is acked, sw_cnn_done pulses one cycle and the FSM returns to IDLE. go high on that same cycle is not accepted; go is accepted in IDLE only.
- Degenerate sizes: y_m > x_m or y_n > x_n produces zero windows; done pulses right after RD_BIAS.

Test Plan:
- 28×28 data, 5×5 weights, bias 0, gnt 1 cycle after each req: 576 writes at addr_z+0..575; each data2write_out and activation matches the software reference; one done pulse.
- All data 10, all weights 1, bias 0, 5×5 → data2write_out 250, activation 250 for every window.
- All data 20, weights 1 → 500 → activation 255 (saturates); weights −1 → −500 → activation 0.
- Bias bytes 0..3 = 0x9C,0xFF,0xFF,0xFF (−100) with data 10, weights 1 → 150 / 150.
- pic valid held high for 3 cycles after the RD_PIC0 capture → no extra capture, weights read once, results unchanged.
- rst_n pulsed low mid-window → all outputs 0, FSM in IDLE, no done; a fresh go completes a correct run.

Source files
------------

// File: rtl/cnn_conv_engine_if.sv
// Memory-fabric bundle for the convolution engine: three read ports
// (data, weights, bias) and one byte-write port.
interface cnn_conv_engine_if #(
    parameter int ADDR_WIDTH      = 19,
    parameter int MAX_BYTES_TO_WR = 5
);
    logic                         pic_mem_req;
    logic [ADDR_WIDTH-1:0]        pic_mem_start_addr;
    logic [5:0]                   pic_mem_size_bytes;
    logic                         pic_mem_valid;
    logic [255:0]                 pic_mem_data;
    logic [4:0]                   pic_mem_last_valid;
    logic                         pic_last;

    logic                         wgt_mem_req;
    logic [ADDR_WIDTH-1:0]        wgt_mem_start_addr;
    logic [5:0]                   wgt_mem_size_bytes;
    logic                         wgt_mem_valid;
    logic [255:0]                 wgt_mem_data;
    logic [4:0]                   wgt_mem_last_valid;
    logic                         wgt_last;

    logic                         bias_mem_req;
    logic [ADDR_WIDTH-1:0]        bias_mem_start_addr;
    logic [5:0]                   bias_mem_size_bytes;
    logic                         bias_mem_valid;
    logic [255:0]                 bias_mem_data;
    logic [4:0]                   bias_mem_last_valid;
    logic                         bias_last;

    logic                         wr_mem_req;
    logic [ADDR_WIDTH-1:0]        wr_mem_start_addr;
    logic [2:0]                   wr_mem_size_bytes;
    logic [8*MAX_BYTES_TO_WR-1:0] wr_mem_data;
    logic                         wr_mem_ack;

    modport master (
        output pic_mem_req, pic_mem_start_addr, pic_mem_size_bytes,
        input  pic_mem_valid, pic_mem_data, pic_mem_last_valid, pic_last,
        output wgt_mem_req, wgt_mem_start_addr, wgt_mem_size_bytes,
        input  wgt_mem_valid, wgt_mem_data, wgt_mem_last_valid, wgt_last,
        output bias_mem_req, bias_mem_start_addr, bias_mem_size_bytes,
        input  bias_mem_valid, bias_mem_data, bias_mem_last_valid, bias_last,
        output wr_mem_req, wr_mem_start_addr, wr_mem_size_bytes, wr_mem_data,
        input  wr_mem_ack
    );

    modport slave (
        input  pic_mem_req, pic_mem_start_addr, pic_mem_size_bytes,
        output pic_mem_valid, pic_mem_data, pic_mem_last_valid, pic_last,
        input  wgt_mem_req, wgt_mem_start_addr, wgt_mem_size_bytes,
        output wgt_mem_valid, wgt_mem_data, wgt_mem_last_valid, wgt_last,
        input  bias_mem_req, bias_mem_start_addr, bias_mem_size_bytes,
        output bias_mem_valid, bias_mem_data, bias_mem_last_valid, bias_last,
        input  wr_mem_req, wr_mem_start_addr, wr_mem_size_bytes, wr_mem_data,
        output wr_mem_ack
    );
endinterface

// File: rtl/cnn_conv_engine.sv
// Single-channel 2-D convolution engine: streams data rows and weights from memory,
// accumulates each window's dot product, adds bias, applies ReLU/saturation, writes one byte per window.
module cnn_conv_engine #(
    parameter int ADDR_WIDTH      = 19,
    parameter int X_ROWS_NUM      = 28,
    parameter int X_COLS_NUM      = 28,
    parameter int X_LOG2_ROWS_NUM = $clog2(X_ROWS_NUM),
    parameter int X_LOG2_COLS_NUM = $clog2(X_COLS_NUM),
    parameter int Y_ROWS_NUM      = 5,
    parameter int Y_COLS_NUM      = 5,
    parameter int Y_LOG2_ROWS_NUM = $clog2(Y_ROWS_NUM),
    parameter int Y_LOG2_COLS_NUM = $clog2(Y_COLS_NUM),
    parameter int JUMP_COL        = 1,
    parameter int JUMP_ROW        = 1,
    parameter int DP_DEPTH        = 5,
    parameter int ACT_SHIFT       = 0,
    parameter int MAX_BYTES_TO_WR = 5
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sw_cnn_go,
    output logic                       sw_cnn_done,
    output logic                       cnn_sw_busy_ind,
    input  logic [ADDR_WIDTH-1:0]      sw_cnn_addr_x,
    input  logic [ADDR_WIDTH-1:0]      sw_cnn_addr_y,
    input  logic [ADDR_WIDTH-1:0]      sw_cnn_addr_z,
    input  logic [ADDR_WIDTH-1:0]      sw_cnn_addr_bias,
    input  logic [X_LOG2_ROWS_NUM:0]   sw_cnn_x_m,
    input  logic [X_LOG2_COLS_NUM:0]   sw_cnn_x_n,
    input  logic [Y_LOG2_ROWS_NUM:0]   sw_cnn_y_m,
    input  logic [Y_LOG2_COLS_NUM:0]   sw_cnn_y_n,
    cnn_conv_engine_if.master          bus,
    output logic signed [31:0]         data2write_out,
    output logic [7:0]                 activation_out_smpl
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD_PIC0 = 3'd1;
    localparam logic [2:0] S_RD_WGT  = 3'd2;
    localparam logic [2:0] S_RD_BIAS = 3'd3;
    localparam logic [2:0] S_RD_ROWS = 3'd4;
    localparam logic [2:0] S_CALC    = 3'd5;
    localparam logic [2:0] S_WRITE   = 3'd6;
    localparam logic [2:0] S_DONE    = 3'd7;

    localparam int CNT_W = $clog2(DP_DEPTH + 1);

    logic [2:0]                  state;
    logic [ADDR_WIDTH-1:0]       addr_x, addr_y, addr_z, addr_bias;
    logic [X_LOG2_ROWS_NUM:0]    x_m;
    logic [X_LOG2_COLS_NUM:0]    x_n;
    logic [Y_LOG2_ROWS_NUM:0]    y_m;
    logic [Y_LOG2_COLS_NUM:0]    y_n;
    logic [X_LOG2_ROWS_NUM:0]    win_i;
    logic [X_LOG2_COLS_NUM:0]    win_j;
    logic [Y_LOG2_ROWS_NUM:0]    row;
    logic [ADDR_WIDTH-1:0]       win_idx;
    logic [CNT_W-1:0]            dp_cnt;
    logic signed [7:0]           wgt  [Y_ROWS_NUM][Y_COLS_NUM];
    logic [7:0]                  pic0 [Y_COLS_NUM];
    logic signed [31:0]          acc;
    logic signed [31:0]          bias;

    // Window geometry and the address of the row currently being fetched.
    int                          i_max, j_max, row_off;
    logic                        has_windows, last_row, last_col, last_window;
    logic [ADDR_WIDTH-1:0]       row_addr;
    logic [5:0]                  wgt_size;

    always_comb begin
        i_max       = (int'(x_m) - int'(y_m)) / JUMP_ROW;
        j_max       = (int'(x_n) - int'(y_n)) / JUMP_COL;
        has_windows = (int'(y_m) <= int'(x_m)) && (int'(y_n) <= int'(x_n));
        last_row    = (int'(row) + 1) >= int'(y_m);
        last_col    = int'(win_j) >= j_max;
        last_window = last_col && (int'(win_i) >= i_max);
        row_off     = (int'(win_i) * JUMP_ROW + int'(row)) * int'(x_n) + int'(win_j) * JUMP_COL;
        row_addr    = addr_x + ADDR_WIDTH'(row_off);
        wgt_size    = 6'(int'(y_m) * int'(y_n));
    end

    // Row-0 data of the first window arrives before the weights, so it is
    // parked in pic0 and folded into the accumulator when the bias lands.
    logic [7:0]                  dot_bytes [Y_COLS_NUM];
    logic [Y_LOG2_ROWS_NUM-1:0]  dot_row;
    logic signed [31:0]          pix_ext, wgt_ext, row_dot;

    // NOTE: every variable gets a default before any conditional logic, so no latch is inferred.
    always_comb begin
        dot_row = (state == S_RD_BIAS) ? '0 : row[Y_LOG2_ROWS_NUM-1:0];
        row_dot = '0;
        pix_ext = '0;
        wgt_ext = '0;
        for (int c = 0; c < Y_COLS_NUM; c++) begin
            dot_bytes[c] = (state == S_RD_BIAS) ? pic0[c] : bus.pic_mem_data[8*c +: 8];
            pix_ext      = 32'(dot_bytes[c]);
            wgt_ext      = 32'(wgt[dot_row][c]);
            // NOTE: blocking assignments here build the running sum within one evaluation.
            if (c < int'(y_n))
                row_dot = row_dot + pix_ext * wgt_ext;
        end
    end

    logic signed [31:0] result, shifted;
    logic [7:0]         act;

    always_comb begin
        result  = acc + bias;
        shifted = result >>> ACT_SHIFT;
        if (result < 0)
            act = 8'd0;
        else if (shifted > 32'sd255)
            act = 8'hFF;
        else
            act = shifted[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                   <= S_IDLE;
            sw_cnn_done             <= 1'b0;
            cnn_sw_busy_ind         <= 1'b0;
            addr_x                  <= '0;
            addr_y                  <= '0;
            addr_z                  <= '0;
            addr_bias               <= '0;
            x_m                     <= '0;
            x_n                     <= '0;
            y_m                     <= '0;
            y_n                     <= '0;
            win_i                   <= '0;
            win_j                   <= '0;
            row                     <= '0;
            win_idx                 <= '0;
            dp_cnt                  <= '0;
            acc                     <= '0;
            bias                    <= '0;
            data2write_out          <= '0;
            activation_out_smpl     <= '0;
            bus.pic_mem_req         <= 1'b0;
            bus.pic_mem_start_addr  <= '0;
            bus.pic_mem_size_bytes  <= '0;
            bus.wgt_mem_req         <= 1'b0;
            bus.wgt_mem_start_addr  <= '0;
            bus.wgt_mem_size_bytes  <= '0;
            bus.bias_mem_req        <= 1'b0;
            bus.bias_mem_start_addr <= '0;
            bus.bias_mem_size_bytes <= '0;
            bus.wr_mem_req          <= 1'b0;
            bus.wr_mem_start_addr   <= '0;
            bus.wr_mem_size_bytes   <= '0;
            bus.wr_mem_data         <= '0;
            // NOTE: the weight and row-0 arrays are register files, so they are cleared like any other state.
            for (int r = 0; r < Y_ROWS_NUM; r++)
                for (int c = 0; c < Y_COLS_NUM; c++)
                    wgt[r][c] <= '0;
            for (int c = 0; c < Y_COLS_NUM; c++)
                pic0[c] <= '0;
        end else begin
            sw_cnn_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sw_cnn_go) begin
                        addr_x          <= sw_cnn_addr_x;
                        addr_y          <= sw_cnn_addr_y;
                        addr_z          <= sw_cnn_addr_z;
                        addr_bias       <= sw_cnn_addr_bias;
                        x_m             <= sw_cnn_x_m;
                        x_n             <= sw_cnn_x_n;
                        y_m             <= sw_cnn_y_m;
                        y_n             <= sw_cnn_y_n;
                        win_i           <= '0;
                        win_j           <= '0;
                        row             <= '0;
                        win_idx         <= '0;
                        acc             <= '0;
                        cnn_sw_busy_ind <= 1'b1;
                        state           <= S_RD_PIC0;
                    end
                end

                S_RD_PIC0: begin
                    if (!bus.pic_mem_req) begin
                        bus.pic_mem_req        <= 1'b1;
                        bus.pic_mem_start_addr <= row_addr;
                        bus.pic_mem_size_bytes <= 6'(y_n);
                    end else if (bus.pic_mem_valid) begin
                        bus.pic_mem_req <= 1'b0;
                        for (int c = 0; c < Y_COLS_NUM; c++)
                            pic0[c] <= bus.pic_mem_data[8*c +: 8];
                        state <= S_RD_WGT;
                    end
                end

                S_RD_WGT: begin
                    if (!bus.wgt_mem_req) begin
                        bus.wgt_mem_req        <= 1'b1;
                        bus.wgt_mem_start_addr <= addr_y;
                        bus.wgt_mem_size_bytes <= wgt_size;
                    end else if (bus.wgt_mem_valid) begin
                        bus.wgt_mem_req <= 1'b0;
                        for (int r = 0; r < Y_ROWS_NUM; r++)
                            for (int c = 0; c < Y_COLS_NUM; c++)
                                if (r < int'(y_m) && c < int'(y_n))
                                    wgt[r][c] <= bus.wgt_mem_data[8*(r*int'(y_n) + c) +: 8];
                        state <= S_RD_BIAS;
                    end
                end

                S_RD_BIAS: begin
                    if (!bus.bias_mem_req) begin
                        bus.bias_mem_req        <= 1'b1;
                        bus.bias_mem_start_addr <= addr_bias;
                        bus.bias_mem_size_bytes <= 6'd4;
                    end else if (bus.bias_mem_valid) begin
                        bus.bias_mem_req <= 1'b0;
                        bias             <= $signed(bus.bias_mem_data[31:0]);
                        acc              <= row_dot;
                        if (!has_windows) begin
                            sw_cnn_done <= 1'b1;
                            state       <= S_DONE;
                        end else if (last_row) begin
                            dp_cnt <= '0;
                            state  <= S_CALC;
                        end else begin
                            row   <= (Y_LOG2_ROWS_NUM+1)'(1);
                            state <= S_RD_ROWS;
                        end
                    end
                end

                S_RD_ROWS: begin
                    if (!bus.pic_mem_req) begin
                        bus.pic_mem_req        <= 1'b1;
                        bus.pic_mem_start_addr <= row_addr;
                        bus.pic_mem_size_bytes <= 6'(y_n);
                    end else if (bus.pic_mem_valid) begin
                        bus.pic_mem_req <= 1'b0;
                        acc             <= acc + row_dot;
                        if (last_row) begin
                            dp_cnt <= '0;
                            state  <= S_CALC;
                        end else begin
                            row <= row + (Y_LOG2_ROWS_NUM+1)'(1);
                        end
                    end
                end

                S_CALC: begin
                    if (dp_cnt == CNT_W'(DP_DEPTH - 1)) begin
                        data2write_out        <= result;
                        activation_out_smpl   <= act;
                        acc                   <= '0;
                        bus.wr_mem_req        <= 1'b1;
                        bus.wr_mem_start_addr <= addr_z + win_idx;
                        bus.wr_mem_size_bytes <= 3'd1;
                        bus.wr_mem_data       <= (8*MAX_BYTES_TO_WR)'(act);
                        state                 <= S_WRITE;
                    end else begin
                        dp_cnt <= dp_cnt + CNT_W'(1);
                    end
                end

                S_WRITE: begin
                    if (bus.wr_mem_req && bus.wr_mem_ack) begin
                        bus.wr_mem_req <= 1'b0;
                        win_idx        <= win_idx + ADDR_WIDTH'(1);
                        row            <= '0;
                        if (last_window) begin
                            sw_cnn_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            if (last_col) begin
                                win_j <= '0;
                                win_i <= win_i + (X_LOG2_ROWS_NUM+1)'(1);
                            end else begin
                                win_j <= win_j + (X_LOG2_COLS_NUM+1)'(1);
                            end
                            state <= S_RD_ROWS;
                        end
                    end
                end

                S_DONE: begin
                    cnn_sw_busy_ind <= 1'b0;
                    state           <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

    // Length/last indications are not needed: sizes are always known up front.
    logic unused_inputs;
    assign unused_inputs = ^{bus.pic_mem_last_valid, bus.pic_last, bus.wgt_mem_last_valid,
                             bus.wgt_last, bus.bias_mem_last_valid, bus.bias_last,
                             bus.bias_mem_data[255:32], bus.pic_mem_data[255:8*Y_COLS_NUM]};

endmodule

// File: tb/tb_cnn_conv_engine.sv
// Scoreboard bench for cnn_conv_engine: a byte-array memory model serves the read ports,
// a reference convolution fills the expected-write queue, and each write pops and compares.
module tb_cnn_conv_engine;
    localparam int ADDR_WIDTH = 19;
    localparam int MAXB       = 5;
    localparam int X_BASE     = 0;
    localparam int Y_BASE     = 1024;
    localparam int B_BASE     = 1100;
    localparam int Z_BASE     = 2048;
    localparam int TIMEOUT    = 40000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic                  go;
    logic                  done, busy;
    logic [ADDR_WIDTH-1:0] addr_x, addr_y, addr_z, addr_b;
    logic [5:0]            x_m, x_n;
    logic [3:0]            y_m, y_n;
    logic signed [31:0]    d2w;
    logic [7:0]            act_o;

    cnn_conv_engine_if #(.ADDR_WIDTH(ADDR_WIDTH), .MAX_BYTES_TO_WR(MAXB)) mem_if ();

    cnn_conv_engine dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .sw_cnn_go           (go),
        .sw_cnn_done         (done),
        .cnn_sw_busy_ind     (busy),
        .sw_cnn_addr_x       (addr_x),
        .sw_cnn_addr_y       (addr_y),
        .sw_cnn_addr_z       (addr_z),
        .sw_cnn_addr_bias    (addr_b),
        .sw_cnn_x_m          (x_m),
        .sw_cnn_x_n          (x_n),
        .sw_cnn_y_m          (y_m),
        .sw_cnn_y_n          (y_n),
        .bus                 (mem_if),
        .data2write_out      (d2w),
        .activation_out_smpl (act_o)
    );

    typedef struct {
        int addr;
        int d2w;
        int act;
    } exp_t;

    logic [7:0] mem [0:4095];
    exp_t       sb[$];
    int         n_checks = 0;
    int         n_errors = 0;
    int         wgt_reqs = 0;
    bit         pic_hold = 1'b0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] fetch(input int addr, input int size);
        logic [255:0] d = '0;
        for (int k = 0; k < size && k < 32; k++)
            d[8*k +: 8] = mem[(addr + k) & 4095];
        return d;
    endfunction

    // Reference convolution (unit stride, no shift) producing the expected writes.
    function automatic void build_expected(input int xm, input int xn, input int ym, input int yn);
        int   bias, s, idx;
        exp_t e;
        bias = int'({mem[B_BASE+3], mem[B_BASE+2], mem[B_BASE+1], mem[B_BASE]});
        sb.delete();
        idx = 0;
        for (int i = 0; i <= xm - ym; i++)
            for (int j = 0; j <= xn - yn; j++) begin
                s = bias;
                for (int r = 0; r < ym; r++)
                    for (int c = 0; c < yn; c++)
                        s += int'(mem[X_BASE + (i+r)*xn + j + c]) * int'($signed(mem[Y_BASE + r*yn + c]));
                e.addr = Z_BASE + idx;
                e.d2w  = s;
                e.act  = (s < 0) ? 0 : ((s > 255) ? 255 : s);
                sb.push_back(e);
                idx++;
            end
    endfunction

    function automatic void fill(input int base, input int n, input int val, input bit rnd);
        for (int k = 0; k < n; k++)
            mem[base + k] = rnd ? 8'($urandom_range(0, 255)) : 8'(val);
    endfunction

    function automatic void set_bias(input int b);
        logic [31:0] v;
        v = 32'(b);
        for (int k = 0; k < 4; k++)
            mem[B_BASE + k] = v[8*k +: 8];
    endfunction

    // Read responders: valid one cycle after req is seen, dropped after the capture edge.
    initial begin
        mem_if.pic_mem_valid = 1'b0; mem_if.pic_mem_data = '0;
        mem_if.pic_mem_last_valid = '0; mem_if.pic_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.pic_mem_req === 1'b1) begin
                @(negedge clk);
                mem_if.pic_mem_data       = fetch(int'(mem_if.pic_mem_start_addr), int'(mem_if.pic_mem_size_bytes));
                mem_if.pic_mem_last_valid = 5'(int'(mem_if.pic_mem_size_bytes) - 1);
                mem_if.pic_mem_valid      = 1'b1;
                @(negedge clk);
                if (pic_hold) begin
                    pic_hold            = 1'b0;
                    mem_if.pic_mem_data = '1;
                    repeat (3) @(negedge clk);
                end
                mem_if.pic_mem_valid = 1'b0;
                mem_if.pic_mem_data  = '0;
            end
        end
    end

    initial begin
        mem_if.wgt_mem_valid = 1'b0; mem_if.wgt_mem_data = '0;
        mem_if.wgt_mem_last_valid = '0; mem_if.wgt_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.wgt_mem_req === 1'b1) begin
                wgt_reqs++;
                @(negedge clk);
                mem_if.wgt_mem_data       = fetch(int'(mem_if.wgt_mem_start_addr), int'(mem_if.wgt_mem_size_bytes));
                mem_if.wgt_mem_last_valid = 5'(int'(mem_if.wgt_mem_size_bytes) - 1);
                mem_if.wgt_mem_valid      = 1'b1;
                @(negedge clk);
                mem_if.wgt_mem_valid = 1'b0;
                mem_if.wgt_mem_data  = '0;
            end
        end
    end

    initial begin
        mem_if.bias_mem_valid = 1'b0; mem_if.bias_mem_data = '0;
        mem_if.bias_mem_last_valid = '0; mem_if.bias_last = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.bias_mem_req === 1'b1) begin
                @(negedge clk);
                mem_if.bias_mem_data       = fetch(int'(mem_if.bias_mem_start_addr), int'(mem_if.bias_mem_size_bytes));
                mem_if.bias_mem_last_valid = 5'(int'(mem_if.bias_mem_size_bytes) - 1);
                mem_if.bias_mem_valid      = 1'b1;
                @(negedge clk);
                mem_if.bias_mem_valid = 1'b0;
                mem_if.bias_mem_data  = '0;
            end
        end
    end

    // Write responder: pops the scoreboard on each new request, acks one cycle later.
    initial begin
        exp_t e;
        mem_if.wr_mem_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (mem_if.wr_mem_req === 1'b1) begin
                if (sb.size() == 0) begin
                    check("wr_unexpected", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", longint'(mem_if.wr_mem_start_addr), e.addr);
                    check("wr_size", longint'(mem_if.wr_mem_size_bytes), 1);
                    check("wr_data", longint'(mem_if.wr_mem_data[7:0]), e.act);
                    check("d2w", longint'(d2w), e.d2w);
                    check("act", longint'(act_o), e.act);
                end
                @(negedge clk);
                mem_if.wr_mem_ack = 1'b1;
                @(negedge clk);
                mem_if.wr_mem_ack = 1'b0;
            end
        end
    end

    task automatic start_run(input int xm, input int xn, input int ym, input int yn);
        build_expected(xm, xn, ym, yn);
        wgt_reqs = 0;
        addr_x = ADDR_WIDTH'(X_BASE);
        addr_y = ADDR_WIDTH'(Y_BASE);
        addr_z = ADDR_WIDTH'(Z_BASE);
        addr_b = ADDR_WIDTH'(B_BASE);
        x_m = 6'(xm); x_n = 6'(xn); y_m = 4'(ym); y_n = 4'(yn);
        @(negedge clk);
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        // Scramble the register inputs: the engine must work from its latched copies.
        addr_x = '1; addr_y = '1; addr_z = '1; addr_b = '1;
        x_m = '0; x_n = '0; y_m = '1; y_n = '1;
    endtask

    task automatic run_conv(input string name, input int xm, input int xn, input int ym, input int yn);
        bit seen;
        int extra;
        start_run(xm, xn, ym, yn);
        check({name, "_busy"}, busy, 1);
        seen = 1'b0;
        for (int k = 0; k < TIMEOUT && !seen; k++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({name, "_done"}, seen, 1);
        if (seen) check({name, "_busy_at_done"}, busy, 1);
        extra = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) extra++;
        end
        check({name, "_done_once"}, extra, 0);
        check({name, "_busy_off"}, busy, 0);
        check({name, "_sb_empty"}, sb.size(), 0);
        check({name, "_wgt_reads"}, wgt_reqs, 1);
    endtask

    initial begin
        int dones;
        go = 1'b0;
        addr_x = '0; addr_y = '0; addr_z = '0; addr_b = '0;
        x_m = '0; x_n = '0; y_m = '0; y_n = '0;
        fill(0, 4096, 0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_d2w", d2w, 0);
        check("rst_act", act_o, 0);
        check("rst_pic_req", mem_if.pic_mem_req, 0);
        check("rst_wr_req", mem_if.wr_mem_req, 0);

        // Full-size random run.
        fill(X_BASE, 784, 0, 1'b1);
        fill(Y_BASE, 25, 0, 1'b1);
        set_bias(0);
        run_conv("full", 28, 28, 5, 5);

        // Constant patterns: in range, saturating high, clamped negative, with bias.
        fill(X_BASE, 72, 10, 1'b0);
        fill(Y_BASE, 25, 1, 1'b0);
        run_conv("const250", 8, 9, 5, 5);
        fill(X_BASE, 72, 20, 1'b0);
        run_conv("sat_hi", 8, 9, 5, 5);
        fill(Y_BASE, 25, 8'hFF, 1'b0);
        run_conv("neg_zero", 8, 9, 5, 5);
        fill(X_BASE, 72, 10, 1'b0);
        fill(Y_BASE, 25, 1, 1'b0);
        set_bias(-100);
        run_conv("bias_m100", 8, 9, 5, 5);

        // Stray valid on the data port after the first capture, non-square window.
        fill(X_BASE, 49, 0, 1'b1);
        fill(Y_BASE, 12, 0, 1'b1);
        set_bias(1234);
        pic_hold = 1'b1;
        run_conv("hold_valid", 7, 7, 3, 4);

        // Single-row window, then windows that do not fit.
        fill(Y_BASE, 3, 0, 1'b1);
        set_bias(-50);
        run_conv("one_row", 4, 6, 1, 3);
        run_conv("degen_rows", 3, 8, 4, 2);
        run_conv("degen_cols", 6, 3, 2, 5);

        // Reset in the middle of a run aborts it; a fresh run must then complete.
        fill(X_BASE, 100, 10, 1'b0);
        fill(Y_BASE, 25, 1, 1'b0);
        set_bias(0);
        start_run(10, 10, 5, 5);
        dones = 0;
        repeat (60) begin
            @(negedge clk);
            if (done) dones++;
        end
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_d2w", d2w, 0);
        check("midrst_act", act_o, 0);
        check("midrst_pic_req", mem_if.pic_mem_req, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("midrst_no_done", dones, 0);
        check("midrst_idle_busy", busy, 0);
        check("midrst_idle_req", mem_if.pic_mem_req, 0);
        run_conv("after_rst", 10, 10, 5, 5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
